// File: rtl/fifo_controller.sv
// fifo_controller: Moore FSM that sequences FIFO write/read transactions and
// drives every datapath control strobe.
//
// Handshake: a requester raises wr_req/rd_req and holds it until the matching
// ack. The request is sampled only in IDLE. wr_ack marks the cycle in which
// the write buffer captures DataIn. rd_ack marks the start of a read, and
// rd_valid pulses two cycles later, when DataOut holds the new word.
// A request still high after its ack is serviced again on the next visit to
// IDLE.
module fifo_controller #(
    parameter int SETTLE_CYCLES = 1,   // 1..7
    parameter bit WRITE_FIRST   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic       empty,
    input  logic       full,
    output logic       wr_ack,
    output logic       rd_ack,
    output logic       rd_valid,
    output logic       err_overflow,
    output logic       err_underflow,
    output logic       ClearReadBuff,
    output logic       ClearWriteBuff,
    output logic       ClearFIFO,
    output logic       ClearPoint,
    output logic       ClearStaReg,
    output logic       LoadWriteBuff,
    output logic       LoadReadBuff,
    output logic       ChipEnable,
    output logic       OutEnable,
    output logic       Write,
    output logic       sel,
    output logic       EnableP,
    output logic [3:0] fsm_state
);

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        IDLE   = 4'd1,
        W_LOAD = 4'd2,
        W_MEM  = 4'd3,
        W_PTR  = 4'd4,
        R_MEM  = 4'd5,
        R_LOAD = 4'd6,
        R_PTR  = 4'd7,
        SETTLE = 4'd8
    } state_t;

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [2:0] settle_cnt;
    logic       write_pri;   // 1: write wins a tie
    logic       wr_ok;
    logic       rd_ok;
    logic       grant_wr;
    logic       grant_rd;

    assign fsm_state = state;

    // Eligibility and tie-break; grants only mean anything in IDLE.
    assign wr_ok    = wr_req & ~full;
    assign rd_ok    = rd_req & ~empty;
    assign grant_wr = (state == IDLE) & wr_ok & (~rd_ok | write_pri);
    assign grant_rd = (state == IDLE) & rd_ok & (~wr_ok | ~write_pri);

    // State register; reset from any state lands in INIT.
    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= next_state;
    end

    // Settle counter, tie-break priority and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt    <= 3'd0;
            write_pri     <= WRITE_FIRST;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (state == SETTLE && settle_cnt != SETTLE_LAST)
                settle_cnt <= settle_cnt + 3'd1;
            else
                settle_cnt <= 3'd0;
            if (grant_wr | grant_rd)
                write_pri <= ~write_pri;
            if (state == IDLE && wr_req && full)
                err_overflow <= 1'b1;
            if (state == IDLE && rd_req && empty)
                err_underflow <= 1'b1;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            INIT:    next_state = IDLE;
            IDLE: begin
                if (grant_wr)      next_state = W_LOAD;
                else if (grant_rd) next_state = R_MEM;
                else               next_state = IDLE;
            end
            W_LOAD:  next_state = W_MEM;
            W_MEM:   next_state = W_PTR;
            W_PTR:   next_state = SETTLE;
            R_MEM:   next_state = R_LOAD;
            R_LOAD:  next_state = R_PTR;
            R_PTR:   next_state = SETTLE;
            SETTLE:  next_state = (settle_cnt == SETTLE_LAST) ? IDLE : SETTLE;
            default: next_state = INIT;
        endcase
    end

    // Strobe decode from the state register only.
    always_comb begin
        wr_ack         = 1'b0;
        rd_ack         = 1'b0;
        rd_valid       = 1'b0;
        ClearReadBuff  = 1'b0;
        ClearWriteBuff = 1'b0;
        ClearFIFO      = 1'b0;
        ClearPoint     = 1'b0;
        ClearStaReg    = 1'b0;
        LoadWriteBuff  = 1'b0;
        LoadReadBuff   = 1'b0;
        ChipEnable     = 1'b0;
        OutEnable      = 1'b0;
        Write          = 1'b0;
        sel            = 1'b0;
        EnableP        = 1'b0;
        case (state)
            INIT: begin
                ClearReadBuff  = 1'b1;
                ClearWriteBuff = 1'b1;
                ClearFIFO      = 1'b1;
                ClearPoint     = 1'b1;
                ClearStaReg    = 1'b1;
            end
            W_LOAD: begin
                LoadWriteBuff = 1'b1;
                wr_ack        = 1'b1;
            end
            W_MEM: begin
                ChipEnable = 1'b1;
                Write      = 1'b1;
                sel        = 1'b1;
            end
            W_PTR: begin
                sel     = 1'b1;
                EnableP = 1'b1;
            end
            R_MEM: begin
                ChipEnable = 1'b1;
                OutEnable  = 1'b1;
                rd_ack     = 1'b1;
            end
            R_LOAD: begin
                ChipEnable   = 1'b1;
                OutEnable    = 1'b1;
                LoadReadBuff = 1'b1;
            end
            R_PTR: begin
                EnableP  = 1'b1;
                rd_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fifo_controller.sv
// tb_fifo_controller: directed checks of fifo_controller sequencing, arbitration,
// error flags and reset abort. Two instances share inputs: SETTLE_CYCLES=1 and 3.
module tb_fifo_controller;

    // Bit positions inside the packed output vectors
    localparam int B_WACK = 16, B_RACK = 15, B_RVAL = 14, B_OVF = 13, B_UNF = 12;
    localparam int B_CRB = 11, B_CWB = 10, B_CF = 9, B_CP = 8, B_CS = 7;
    localparam int B_LWB = 6, B_LRB = 5, B_CE = 4, B_OE = 3, B_WR = 2, B_SEL = 1, B_EP = 0;

    localparam logic [16:0] E_ZERO = 17'd0;
    localparam logic [16:0] E_OVF  = 17'd1 << B_OVF;
    localparam logic [16:0] E_UNF  = 17'd1 << B_UNF;
    localparam logic [16:0] E_INIT = (17'd1 << B_CRB) | (17'd1 << B_CWB) | (17'd1 << B_CF)
                                   | (17'd1 << B_CP) | (17'd1 << B_CS);
    localparam logic [16:0] E_WLD  = (17'd1 << B_WACK) | (17'd1 << B_LWB);
    localparam logic [16:0] E_WMEM = (17'd1 << B_CE) | (17'd1 << B_WR) | (17'd1 << B_SEL);
    localparam logic [16:0] E_WPTR = (17'd1 << B_SEL) | (17'd1 << B_EP);
    localparam logic [16:0] E_RMEM = (17'd1 << B_RACK) | (17'd1 << B_CE) | (17'd1 << B_OE);
    localparam logic [16:0] E_RLD  = (17'd1 << B_CE) | (17'd1 << B_OE) | (17'd1 << B_LRB);
    localparam logic [16:0] E_RPTR = (17'd1 << B_EP) | (17'd1 << B_RVAL);

    localparam logic [3:0] S_INIT = 4'd0, S_IDLE = 4'd1, S_SETTLE = 4'd8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr_req = 1'b0, rd_req = 1'b0, empty = 1'b1, full = 1'b0;
    logic [16:0] outs, outs3;
    logic [3:0]  st, st3;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_controller #(.SETTLE_CYCLES(1), .WRITE_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req),
        .empty(empty), .full(full),
        .wr_ack(outs[B_WACK]), .rd_ack(outs[B_RACK]), .rd_valid(outs[B_RVAL]),
        .err_overflow(outs[B_OVF]), .err_underflow(outs[B_UNF]),
        .ClearReadBuff(outs[B_CRB]), .ClearWriteBuff(outs[B_CWB]), .ClearFIFO(outs[B_CF]),
        .ClearPoint(outs[B_CP]), .ClearStaReg(outs[B_CS]),
        .LoadWriteBuff(outs[B_LWB]), .LoadReadBuff(outs[B_LRB]),
        .ChipEnable(outs[B_CE]), .OutEnable(outs[B_OE]), .Write(outs[B_WR]),
        .sel(outs[B_SEL]), .EnableP(outs[B_EP]), .fsm_state(st)
    );

    fifo_controller #(.SETTLE_CYCLES(3), .WRITE_FIRST(1'b0)) dut3 (
        .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req),
        .empty(empty), .full(full),
        .wr_ack(outs3[B_WACK]), .rd_ack(outs3[B_RACK]), .rd_valid(outs3[B_RVAL]),
        .err_overflow(outs3[B_OVF]), .err_underflow(outs3[B_UNF]),
        .ClearReadBuff(outs3[B_CRB]), .ClearWriteBuff(outs3[B_CWB]), .ClearFIFO(outs3[B_CF]),
        .ClearPoint(outs3[B_CP]), .ClearStaReg(outs3[B_CS]),
        .LoadWriteBuff(outs3[B_LWB]), .LoadReadBuff(outs3[B_LRB]),
        .ChipEnable(outs3[B_CE]), .OutEnable(outs3[B_OE]), .Write(outs3[B_WR]),
        .sel(outs3[B_SEL]), .EnableP(outs3[B_EP]), .fsm_state(st3)
    );

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // 1: reset two cycles, one INIT cycle, then IDLE
        reset = 1'b1;
        tick();
        tick();
        check("init_outs", 32'(outs), 32'(E_INIT));
        check("init_state", 32'(st), 32'(S_INIT));
        reset = 1'b0;
        tick();
        check("idle_outs", 32'(outs), 32'(E_ZERO));
        check("idle_state", 32'(st), 32'(S_IDLE));

        // 2: single write
        empty = 1'b1; full = 1'b0; wr_req = 1'b1;
        tick(); check("w_load", 32'(outs), 32'(E_WLD));
        wr_req = 1'b0;
        tick(); check("w_mem", 32'(outs), 32'(E_WMEM));
        tick(); check("w_ptr", 32'(outs), 32'(E_WPTR));
        tick(); check("w_settle", 32'(outs), 32'(E_ZERO));
        tick(); check("w_idle", 32'(st), 32'(S_IDLE));

        // 3: single read
        empty = 1'b0; rd_req = 1'b1;
        tick(); check("r_mem", 32'(outs), 32'(E_RMEM));
        rd_req = 1'b0;
        tick(); check("r_load", 32'(outs), 32'(E_RLD));
        tick(); check("r_ptr", 32'(outs), 32'(E_RPTR));
        tick(); check("r_settle", 32'(outs), 32'(E_ZERO));
        tick(); check("r_idle", 32'(st), 32'(S_IDLE));

        // 4: both held after reset -> W,R,W,R, ack edges five cycles apart
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        empty = 1'b0; full = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            check((g % 2 == 0) ? "alt_w" : "alt_r", 32'(outs),
                  32'((g % 2 == 0) ? E_WLD : E_RMEM));
            if (g < 3) begin
                for (int k = 0; k < 4; k++) begin
                    tick();
                    check("alt_gap", 32'(outs[B_WACK:B_RACK]), 32'd0);
                end
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        tick(); tick(); tick(); tick();
        check("alt_end", 32'(st), 32'(S_IDLE));

        // 5: overflow / underflow, blocked plus eligible
        full = 1'b1; wr_req = 1'b1;
        tick(); check("ovf_set", 32'(outs), 32'(E_OVF));
        tick(); check("ovf_hold", 32'(outs), 32'(E_OVF));
        wr_req = 1'b0;
        tick(); check("ovf_sticky", 32'(outs), 32'(E_OVF));
        full = 1'b0; empty = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick(); check("unf_with_wr", 32'(outs), 32'(E_WLD | E_OVF | E_UNF));
        wr_req = 1'b0; rd_req = 1'b0;
        tick(); tick(); tick(); tick();
        check("errs_idle", 32'(outs), 32'(E_OVF | E_UNF));
        reset = 1'b1;
        tick(); check("errs_reset", 32'(outs), 32'(E_INIT));
        reset = 1'b0;
        tick(); check("errs_cleared", 32'(outs), 32'(E_ZERO));

        // 6: reset during W_MEM abandons the write
        empty = 1'b0; wr_req = 1'b1;
        tick(); check("ab_w_load", 32'(outs), 32'(E_WLD));
        wr_req = 1'b0;
        tick(); check("ab_w_mem", 32'(outs), 32'(E_WMEM));
        reset = 1'b1;
        tick(); check("ab_init", 32'(outs), 32'(E_INIT));
        reset = 1'b0;
        tick(); check("ab_idle", 32'(outs), 32'(E_ZERO));
        check("ab_idle_state", 32'(st), 32'(S_IDLE));

        // SETTLE_CYCLES=3 instance: three settle cycles, then re-serviced held write
        wr_req = 1'b1;
        tick(); check("s3_w_load", 32'(outs3), 32'(E_WLD));
        tick(); check("s3_w_mem", 32'(outs3), 32'(E_WMEM));
        tick(); check("s3_w_ptr", 32'(outs3), 32'(E_WPTR));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("s3_settle", 32'(st3), 32'(S_SETTLE));
            check("s3_settle_outs", 32'(outs3), 32'(E_ZERO));
        end
        tick(); check("s3_idle", 32'(st3), 32'(S_IDLE));
        tick(); check("s3_w_again", 32'(outs3), 32'(E_WLD));
        wr_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
